// File: rtl/bank_pkg.sv
// bank_pkg: op and FSM state encodings shared by bank_ctrl and the bank top level
package bank_pkg;
    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_SEARCH  = 2'b01,
        OP_MAC     = 2'b10,
        OP_ILLEGAL = 2'b11
    } op_t;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SETUP = 2'b01,
        FIRE  = 2'b10
    } state_t;
endpackage

// File: rtl/bank_ctrl.sv
// bank_ctrl: sequences WRITE, SEARCH and 4-row MAC operations onto the 4x4 bank decoder
module bank_ctrl
    import bank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_addr,
    input  logic [3:0] cmd_data,
    input  logic [3:0] cmd_mask,
    output logic       cs,
    output logic       clk_copy,
    output logic       w_en,
    output logic       mac_en,
    output logic       read_bar,
    output logic [1:0] addr,
    output logic [3:0] data,
    output logic [3:0] data_bar,
    output logic       row_valid,
    output logic       done,
    output logic       err
);
    state_t     state, state_n;
    op_t        op_q, op_n;
    logic [1:0] addr_q, addr_n, row_q, row_n;
    logic [3:0] data_q, data_n, mask_q, mask_n;
    logic       take, ill, in_op, wr, sr, mc, fin;

    assign cmd_ready = (state == IDLE) && !rst;
    assign take      = cmd_valid && cmd_ready;

    always_comb begin
        state_n = state;
        op_n    = op_q;
        addr_n  = addr_q;
        data_n  = data_q;
        mask_n  = mask_q;
        row_n   = row_q;
        ill     = 1'b0;
        if (state == IDLE) begin
            if (take) begin
                op_n    = op_t'(cmd_op);
                addr_n  = cmd_addr;
                data_n  = cmd_data;
                mask_n  = cmd_mask;
                row_n   = 2'd0;
                ill     = op_t'(cmd_op) == OP_ILLEGAL;
                state_n = ill ? IDLE : SETUP;
            end
        end else if (state == SETUP) begin
            state_n = FIRE;
        end else if (op_q == OP_MAC && row_q != 2'd3) begin
            row_n   = row_q + 2'd1;
            state_n = SETUP;
        end else begin
            state_n = IDLE;
        end
    end

    // outputs are decoded from the next state so they register alongside it
    assign in_op = state_n != IDLE;
    assign wr    = in_op && op_n == OP_WRITE;
    assign sr    = in_op && op_n == OP_SEARCH;
    assign mc    = in_op && op_n == OP_MAC;
    assign fin   = state == FIRE && state_n == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_q      <= OP_WRITE;
            addr_q    <= 2'd0;
            data_q    <= 4'd0;
            mask_q    <= 4'd0;
            row_q     <= 2'd0;
            cs        <= 1'b0;
            clk_copy  <= 1'b0;
            w_en      <= 1'b0;
            mac_en    <= 1'b0;
            read_bar  <= 1'b0;
            addr      <= 2'd0;
            data      <= 4'd0;
            data_bar  <= 4'd0;
            row_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            op_q      <= op_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            mask_q    <= mask_n;
            row_q     <= row_n;
            cs        <= in_op;
            clk_copy  <= state_n == FIRE;
            w_en      <= wr;
            mac_en    <= mc;
            read_bar  <= mc && !data_n[row_n];
            addr      <= wr ? addr_n : mc ? row_n : 2'd0;
            data      <= wr ? data_n : sr ? (data_n & ~mask_n) : 4'd0;
            data_bar  <= wr ? ~data_n : sr ? (~data_n & ~mask_n) : 4'd0;
            row_valid <= mc && state_n == FIRE;
            done      <= fin || ill;
            err       <= ill;
        end
    end
endmodule

// File: tb/tb_bank_ctrl.sv
// tb_bank_ctrl: randomized and directed checks of bank_ctrl against a cycle-trace model
module tb_bank_ctrl;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0, cmd_addr = 2'd0;
    logic [3:0] cmd_data = 4'd0, cmd_mask = 4'd0;
    logic       cmd_ready, cs, clk_copy, w_en, mac_en, read_bar, row_valid, done, err;
    logic [1:0] addr;
    logic [3:0] data, data_bar;
    logic [18:0] obs;
    int checks = 0, errors = 0;

    bank_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
        .cs(cs), .clk_copy(clk_copy), .w_en(w_en), .mac_en(mac_en), .read_bar(read_bar),
        .addr(addr), .data(data), .data_bar(data_bar), .row_valid(row_valid),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign obs = {cs, clk_copy, w_en, mac_en, read_bar, addr, data, data_bar,
                  row_valid, done, err, cmd_ready};

    function automatic logic [18:0] idle_vec(logic dn, logic er, logic rdy);
        return {16'b0, dn, er, rdy};
    endfunction

    // step s of a busy operation: even = SETUP, odd = FIRE, MAC row = s/2
    function automatic logic [18:0] busy_vec(logic [1:0] op, logic [1:0] a, logic [3:0] d,
                                             logic [3:0] m, int s);
        logic       fire, w, mc;
        logic [1:0] row, ad;
        logic [3:0] dt, db;
        fire = s[0];
        row  = 2'(s / 2);
        w    = op == 2'b00;
        mc   = op == 2'b10;
        ad   = w ? a : mc ? row : 2'b00;
        dt   = 4'b0;
        db   = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (w || (op == 2'b01 && !m[i])) begin
                dt[i] = d[i];
                db[i] = !d[i];
            end
        end
        return {1'b1, fire, w, mc, mc && !d[row], ad, dt, db, mc && fire, 3'b000};
    endfunction

    task automatic junk();
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_addr  = 2'($urandom);
        cmd_data  = 4'($urandom);
        cmd_mask  = 4'($urandom);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d,
                          input logic [3:0] m, input string tag);
        int n;
        logic [18:0] e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_mask  = m;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready got %b exp 1", tag, cmd_ready);
        end
        n = op == 2'b10 ? 8 : op == 2'b11 ? 0 : 2;
        for (int s = 0; s < n; s++) begin
            @(negedge clk);
            e = busy_vec(op, a, d, m, s);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s step%0d got %b exp %b", tag, s, obs, e);
            end
            junk();
        end
        @(negedge clk);
        e = idle_vec(1'b1, op == 2'b11, 1'b1);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL %s done got %b exp %b", tag, obs, e);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        checks++;
        if (obs !== idle_vec(1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL %s idle got %b exp %b", tag, obs, idle_vec(1'b0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== idle_vec(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset got %b exp %b", obs, idle_vec(1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        idle_check("reset_release");
    endtask

    task automatic test_write();
        do_cmd(2'b00, 2'd2, 4'b1010, 4'b0000, "write");
        idle_check("write");
    endtask

    task automatic test_search();
        do_cmd(2'b01, 2'd3, 4'b1100, 4'b0011, "search");
        idle_check("search");
    endtask

    task automatic test_mac();
        do_cmd(2'b10, 2'd1, 4'b0101, 4'b1111, "mac");
        idle_check("mac");
    endtask

    task automatic test_illegal();
        do_cmd(2'b11, 2'd1, 4'b1111, 4'b0000, "illegal");
        idle_check("illegal");
    endtask

    task automatic test_back_to_back();
        do_cmd(2'b00, 2'd1, 4'b0110, 4'b0000, "b2b_write");
        do_cmd(2'b01, 2'd0, 4'b1001, 4'b0100, "b2b_search");
        do_cmd(2'b10, 2'd0, 4'b1100, 4'b0000, "b2b_mac");
        idle_check("b2b");
    endtask

    task automatic test_reset_mid_mac();
        logic [18:0] e;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_data  = 4'b0110;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            junk();
        end
        e = busy_vec(2'b10, 2'd0, 4'b0110, 4'b0000, 5);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_mac row2 got %b exp %b", obs, e);
        end
        rst = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== idle_vec(1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL rst_mac abort got %b exp %b", obs, idle_vec(1'b0, 1'b0, 1'b0));
        end
        rst = 1'b0;
        idle_check("rst_mac_after");
        idle_check("rst_mac_nodone");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            do_cmd(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), "random");
            if ($urandom_range(1, 0) == 1) idle_check("random");
        end
        idle_check("random_end");
    endtask

    initial begin
        test_reset();
        test_write();
        test_search();
        test_mac();
        test_illegal();
        test_back_to_back();
        test_reset_mid_mac();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bank_ctrl.md
BANK_CTRL -- requirements
Module: bank_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first:
  clk  in  1  single clock; all state updates on rising edge
  rst  in  1  synchronous, active-high reset
  cmd_valid  in  1  command offered
  cmd_ready  out  1  controller can accept a command
  cmd_op  in  2  00 WRITE, 01 SEARCH, 10 MAC, 11 illegal
  cmd_addr  in  2  target row (WRITE only)
  cmd_data  in  4  WRITE data / SEARCH key / MAC input vector (bit i drives row i)
  cmd_mask  in  4  SEARCH only; 1 = bit i don't-care
  cs  out  1  bank select to decoder
  clk_copy  out  1  word-line fire phase to decoder
  w_en  out  1  write mode
  mac_en  out  1  MAC mode
  read_bar  out  1  MAC polarity: 1 = fire WLB, 0 = fire WL
  addr  out  2  row address to decoder
  data  out  4  search/write data lines
  data_bar  out  4  complementary data lines
  row_valid  out  1  MAC row is being fired this cycle
  done  out  1  one-cycle completion pulse
  err  out  1  one-cycle illegal-op pulse, coincident with done
REQ-002 SHALL have no parameters; widths are fixed to match the 4x4 bank.

Function
REQ-003 SHALL use a 3-state FSM: IDLE, SETUP, FIRE.
REQ-004 cmd_ready SHALL be 1 exactly when state is IDLE and rst is 0.
REQ-005 On handshake (cmd_valid & cmd_ready) SHALL latch op, addr, data and mask, clear row counter to 0, and go to SETUP; illegal op goes to IDLE with done=err=1 in the next cycle.
REQ-006 SETUP: cs=1, clk_copy=0, mode/addr/data outputs driven; next state FIRE.
REQ-007 FIRE: cs=1, clk_copy=1, same outputs as preceding SETUP; next state is IDLE, except in MAC with row counter < 3, where the counter increments and the next state is SETUP.
REQ-008 WRITE: w_en=1, mac_en=0, addr=latched addr, data=cmd_data, data_bar=~cmd_data.
REQ-009 SEARCH: w_en=0, mac_en=0, addr=0; per bit i, masked -> data[i]=data_bar[i]=0; unmasked -> data[i]=key[i], data_bar[i]=~key[i].
REQ-010 MAC: w_en=0, mac_en=1, addr=row counter, read_bar=~latched_data[row counter], data=data_bar=0; row_valid=1 only in MAC FIRE cycles.
REQ-011 Latency, handshake in cycle N: WRITE/SEARCH use SETUP at N+1, FIRE at N+2, done at N+3; MAC fires rows 0..3 at N+2, N+4, N+6, N+8 and gives done at N+9; illegal gives done at N+1.
REQ-012 done SHALL be a registered 1-cycle pulse in the first IDLE cycle after completion; a new command MAY be accepted in that same cycle.
REQ-013 In IDLE, all array outputs (cs, clk_copy, w_en, mac_en, read_bar, addr, data, data_bar, row_valid) SHALL be 0.
REQ-014 cmd_* inputs SHALL be ignored while not in IDLE; latched values hold for the whole operation.

Reset
REQ-015 rst=1 SHALL force IDLE, row counter 0, latched fields 0, done=err=0, and all array outputs 0 on the next edge, including mid-operation (an aborted op gives no done).
REQ-016 rst SHALL take priority over a simultaneous handshake; cmd_ready=0 while rst=1.

Structure
REQ-017 Op encodings (OP_WRITE, OP_SEARCH, OP_MAC) and FSM state encodings SHALL live in a shared package bank_pkg, also used by the bank top level.
REQ-018 SHALL be a single module with no sub-modules; bank_decoder is instantiated beside it at bank top, not inside it.

Verification
REQ-019 Reset mid-MAC: rst pulsed during the row-2 FIRE cycle -> next cycle IDLE, all outputs 0, cmd_ready=1 after rst drops, no done.
REQ-020 WRITE addr=2, data=4'b1010 -> N+1 SETUP cs=1 clk_copy=0 w_en=1 addr=2; N+2 clk_copy=1, data=1010, data_bar=0101; done at N+3.
REQ-021 SEARCH key=4'b1100, mask=4'b0011 -> in FIRE, data=1100 and data_bar=0000; mac_en=w_en=0; done at N+3.
REQ-022 MAC input=4'b0101 -> FIRE at N+2/4/6/8 with addr 0..3, read_bar 0,1,0,1, row_valid=1 only in those cycles; done at N+9.
REQ-023 Back-to-back: cmd_valid held high with WRITE then SEARCH -> second accepted in the done cycle of the first; no idle gap beyond it; cmd_* changes mid-op have no effect.
REQ-024 cmd_op=11 -> done=err=1 at N+1; cs and clk_copy never asserted.
